// File: rtl/pipe_hazard_ctrl.sv
// ----------------------------------------------------------------------------
// pipe_hazard_ctrl : stall/flush/PC-select scheduler and interrupt sequencer
// Optional perf counters: define PIPE_HAZARD_CTRL_PERF_EN.  Rev 1.0
// ----------------------------------------------------------------------------
`default_nettype none

module pipe_hazard_ctrl #(
  parameter int DRAIN_CYCLES = 3,
  parameter int PERF_W       = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [4:0]        i_id_rs,
  input  logic [4:0]        i_id_rt,
  input  logic              i_id_uses_rs,
  input  logic              i_id_uses_rt,
  input  logic [31:0]       i_id_pc,
  input  logic              i_ex_memread,
  input  logic [4:0]        i_ex_rt,
  input  logic              i_ex_branch_taken,
  input  logic              i_id_jump,
  input  logic              i_mem_busy,
  input  logic              i_irq,
  output logic              o_if_en,
  output logic              o_if2id_en,
  output logic              o_id2ex_en,
  output logic              o_ex2mem_en,
  output logic              o_mem2wb_en,
  output logic              o_if2id_flush,
  output logic              o_id2ex_flush,
  output logic [1:0]        o_pc_sel,
  output logic              o_irq_ack,
  output logic [31:0]       o_epc,
  output logic [PERF_W-1:0] o_perf_stall,
  output logic [PERF_W-1:0] o_perf_flush
);

  typedef enum logic [1:0] {
    S_RUN   = 2'd0,
    S_DRAIN = 2'd1,
    S_ENTER = 2'd2
  } state_t;

  localparam logic [3:0] c_DRAIN_LOAD = 4'(DRAIN_CYCLES - 1);

  state_t      r_state, w_next;
  logic [3:0]  r_cnt, w_cnt_nxt;
  logic [31:0] r_epc, w_epc_nxt;
  logic        w_hazard, w_bubble;
  logic [4:0]  w_en;  // {if, if2id, id2ex, ex2mem, mem2wb}
  logic        w_if2id_flush, w_id2ex_flush, w_irq_ack;
  logic [1:0]  w_pc_sel;

  assign w_hazard = i_ex_memread && (i_ex_rt != 5'd0) &&
                    ((i_id_uses_rs && (i_id_rs == i_ex_rt)) ||
                     (i_id_uses_rt && (i_id_rt == i_ex_rt)));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= S_RUN;
      r_cnt   <= 4'd0;
      r_epc   <= 32'd0;
    end else begin
      r_state <= w_next;
      r_cnt   <= w_cnt_nxt;
      r_epc   <= w_epc_nxt;
    end
  end

  // Outputs are forced to their idle values while rst is held, independent of the clock.
  always_comb begin
    w_next        = r_state;
    w_cnt_nxt     = r_cnt;
    w_epc_nxt     = r_epc;
    w_en          = 5'b11111;
    w_if2id_flush = 1'b0;
    w_id2ex_flush = 1'b0;
    w_pc_sel      = 2'd0;
    w_irq_ack     = 1'b0;
    w_bubble      = 1'b0;
    if (!rst) begin
      if (i_mem_busy) begin
        w_en = 5'b00000;
      end else begin
        case (r_state)
          S_RUN: begin
            if (i_ex_branch_taken) begin
              w_pc_sel      = 2'd2;
              w_if2id_flush = 1'b1;
              w_id2ex_flush = 1'b1;
            end else if (w_hazard) begin
              w_en          = 5'b00111;
              w_id2ex_flush = 1'b1;
              w_bubble      = 1'b1;
            end else if (i_irq && !i_id_pc[31]) begin
              w_en          = 5'b00111;
              w_id2ex_flush = 1'b1;
              w_epc_nxt     = i_id_pc;
              w_cnt_nxt     = c_DRAIN_LOAD;
              w_next        = S_DRAIN;
            end else if (i_id_jump) begin
              w_pc_sel      = 2'd1;
              w_if2id_flush = 1'b1;
            end
          end
          S_DRAIN: begin
            w_en          = 5'b00111;
            w_id2ex_flush = 1'b1;
            if (r_cnt == 4'd0) begin
              w_next = S_ENTER;
            end else begin
              w_cnt_nxt = r_cnt - 4'd1;
            end
          end
          S_ENTER: begin
            w_pc_sel      = 2'd3;
            w_irq_ack     = 1'b1;
            w_if2id_flush = 1'b1;
            w_id2ex_flush = 1'b1;
            w_next        = S_RUN;
          end
          default: w_next = S_RUN;
        endcase
      end
    end
  end

  assign {o_if_en, o_if2id_en, o_id2ex_en, o_ex2mem_en, o_mem2wb_en} = w_en;
  assign o_if2id_flush = w_if2id_flush;
  assign o_id2ex_flush = w_id2ex_flush;
  assign o_pc_sel      = w_pc_sel;
  assign o_irq_ack     = w_irq_ack;
  assign o_epc         = r_epc;

`ifdef PIPE_HAZARD_CTRL_PERF_EN
  logic [PERF_W-1:0] r_perf_stall, r_perf_flush;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_perf_stall <= '0;
      r_perf_flush <= '0;
    end else begin
      if (i_mem_busy || w_bubble || (r_state == S_DRAIN))
        r_perf_stall <= r_perf_stall + 1'b1;
      if (w_if2id_flush || w_id2ex_flush)
        r_perf_flush <= r_perf_flush + 1'b1;
    end
  end

  assign o_perf_stall = r_perf_stall;
  assign o_perf_flush = r_perf_flush;
`else
  assign o_perf_stall = '0;
  assign o_perf_flush = '0;
`endif

endmodule

`default_nettype wire

// File: doc/pipe_hazard_ctrl.md
Name: pipe_hazard_ctrl

Overview:
- Central stall/flush/PC-select scheduler for the 5-stage MIPS pipeline (IF, IF2ID, ID2EX, EX2MEM, MEM2WB).
- Drives every stage-register EN and flush, selects the next-PC source, and sequences interrupt entry: drain, then vector.
- Sits beside Control; its outputs feed the stage registers and the PC mux.

Parameters:
DRAIN_CYCLES, 3, cycles spent draining EX/MEM/WB before the interrupt vector is taken (legal 1..15)
PERF_W, 32, width of the performance counters (optional feature only)

Ports:
clk  input  1  system clock
rst  input  1  asynchronous, active-high reset
id_rs  input  5  Rs field of the instruction in ID
id_rt  input  5  Rt field of the instruction in ID
id_uses_rs  input  1  ID instruction reads Rs
id_uses_rt  input  1  ID instruction reads Rt
id_pc  input  32  PC of the instruction in ID
ex_memread  input  1  instruction in EX is a load
ex_rt  input  5  destination register of the load in EX
ex_branch_taken  input  1  branch in EX resolved taken
id_jump  input  1  ID instruction is j/jal/jr/jalr
mem_busy  input  1  data memory or peripheral wait request
irq  input  1  level interrupt request
if_en, if2id_en, id2ex_en, ex2mem_en, mem2wb_en  output  1 each  stage-register enables
if2id_flush, id2ex_flush  output  1 each  synchronous bubble insert
pc_sel  output  2  0 = PC+4, 1 = jump, 2 = branch, 3 = interrupt vector
irq_ack  output  1  one-cycle pulse on vector entry
epc  output  32  PC of the instruction preempted by the interrupt
perf_stall  output  PERF_W  stall-cycle count
perf_flush  output  PERF_W  flush-event count

Behaviour:
- States: RUN, DRAIN, ENTER. State, drain counter and epc are registered; all other outputs are combinational from state and inputs.
- Reset (async, while rst=1): state = RUN, counter = 0, epc = 0. Resulting outputs: all en = 1, flushes = 0, pc_sel = 0, irq_ack = 0, perf counters = 0.
- Global freeze: mem_busy = 1 in any state forces all five en = 0, flushes = 0, pc_sel = 0 and irq_ack = 0. State and counter hold.
- Load-use hazard: ex_memread & ex_rt != 0 & ((id_uses_rs & id_rs == ex_rt) | (id_uses_rt & id_rt == ex_rt)).
- RUN, without freeze, first matching rule wins:
  1. ex_branch_taken: pc_sel = 2, if2id_flush = 1, id2ex_flush = 1. This also overrides a hazard or jump in ID.
  2. Load-use hazard: if_en = 0, if2id_en = 0, id2ex_flush = 1. Exactly one bubble; the next cycle proceeds without a stall.
  3. irq & ~id_pc[31] (kernel mode masks interrupts): epc <= id_pc, counter <= DRAIN_CYCLES-1, go to DRAIN. In the same cycle: if_en = 0, if2id_en = 0, id2ex_flush = 1, which kills the ID instruction.
  4. id_jump: pc_sel = 1, if2id_flush = 1.
  5. Otherwise all en = 1, flushes = 0, pc_sel = 0.
- DRAIN: if_en = 0, if2id_en = 0, id2ex_flush = 1, ex2mem_en = mem2wb_en = 1. Branch and jump inputs are ignored. The counter decrements each unfrozen cycle; at 0 go to ENTER.
- ENTER (one cycle): pc_sel = 3, irq_ack = 1, if_en = 1, if2id_flush = 1, id2ex_flush = 1; then go to RUN.
- irq deasserting during DRAIN does not abort the entry. irq held high after ENTER is masked by id_pc[31] of the handler.
- Reset mid-DRAIN returns to RUN immediately; a pending entry is lost and epc is cleared.
- Latency from irq accepted to irq_ack = DRAIN_CYCLES + 1 unfrozen cycles.

Optional Feature:
- Macro: PIPE_HAZARD_CTRL_PERF_EN.
- Defined:
  - perf_stall increments on every cycle with mem_busy, a load-use bubble, or state DRAIN.
  - perf_flush increments on every cycle where if2id_flush or id2ex_flush = 1.
  - Both counters wrap modulo 2^PERF_W and clear on reset.
- Undefined: both ports are tied to 0 and no counter logic is generated.

Test Plan:
- Reset: assert rst mid-cycle with irq = 1 → outputs change immediately (asynchronously): all en = 1, pc_sel = 0, epc = 0; after release with irq = 0, state stays RUN.
- Load-use: ex_memread = 1, ex_rt = 8, id_rs = 8, id_uses_rs = 1 → one cycle with if_en = if2id_en = 0 and id2ex_flush = 1; same with ex_rt = 0 → no stall.
- Branch over hazard: ex_branch_taken = 1 together with a load-use match and id_jump = 1 → pc_sel = 2 and both flushes = 1, no stall.
- Interrupt: irq = 1, id_pc = 0x0000_0040, DRAIN_CYCLES = 3 → epc = 0x40; irq_ack pulses exactly 4 cycles later with pc_sel = 3; irq dropped after 1 cycle still gives the pulse. With id_pc = 0x8000_0040 → no entry.
- Freeze: mem_busy = 1 for 5 cycles in the middle of DRAIN → all en = 0 and the counter holds; irq_ack arrives 5 cycles late.
- Perf (macro defined): 1 load-use bubble + 2 mem_busy cycles + 1 branch → perf_stall = 3, perf_flush = 2 (load-use id2ex_flush, branch cycle).
